seg7_scan_decoder: RTL

- Receive-side counterpart of the 7-segment display driver path.
- Samples a multiplexed 7-segment bus (digit select, segment pattern, decimal point) and glitch-filters each sample.
- Decodes each stable segment pattern back to BCD and keeps one BCD register per digit position.
- Reports frame completion, illegal patterns, and 9->0 rollovers on a monitored digit (the recovered carry). Used as an on-chip display monitor and as a loopback checker for the counter/display path.

---
 rtl/seg7_scan_decoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Display monitor: samples a multiplexed 7-segment bus, glitch-filters it and
// recovers per-digit BCD, frame completion, pattern errors and monitored-digit carry.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS = 8,
  parameter int SAMPLE_DIV = 16,
  parameter int STABLE     = 4,
  parameter int MON_DIGIT  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2:0]              seg7_sel,
  input  logic [6:0]              seg7_in,
  input  logic                    dpt_in,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digit_bcd,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   dp_flags,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic                    rollover,
  output logic [15:0]             rollover_cnt
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W = $clog2(STABLE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE);
  localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE - 1);

  // Returns {legal, blank, bcd}; neither flag set means an illegal pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      7'b1111110: res = {2'b10, 4'd0};
      7'b0110000: res = {2'b10, 4'd1};
      7'b1101101: res = {2'b10, 4'd2};
      7'b1111001: res = {2'b10, 4'd3};
      7'b0110011: res = {2'b10, 4'd4};
      7'b1011011: res = {2'b10, 4'd5};
      7'b1011111: res = {2'b10, 4'd6};
      7'b1110000: res = {2'b10, 4'd7};
      7'b1111111: res = {2'b10, 4'd8};
      7'b1111011: res = {2'b10, 4'd9};
      7'b0000000: res = {2'b01, 4'd0};
      default:    res = {2'b00, 4'd0};
    endcase
    return res;
  endfunction

  logic [DIV_W-1:0]          div_cnt_r;
  logic [CNT_W-1:0]          stable_cnt_r;
  logic [10:0]               sample_r;
  logic [NUM_DIGITS-1:0]     mask_r;
  logic [4*NUM_DIGITS-1:0]   digit_bcd_r;
  logic [NUM_DIGITS-1:0]     digit_valid_r;
  logic [NUM_DIGITS-1:0]     dp_flags_r;
  logic                      frame_done_r;
  logic                      pattern_err_r;
  logic                      rollover_r;
  logic [15:0]               rollover_cnt_r;

  logic [10:0]               bus_s;
  logic                      tick_s;
  logic                      same_s;
  logic                      commit_s;
  logic [5:0]                dec_s;
  logic                      legal_s;
  logic                      illegal_s;
  logic [3:0]                val_s;
  logic [NUM_DIGITS-1:0]     commit_bit_s;
  logic [NUM_DIGITS-1:0]     mask_next_s;
  logic                      frame_full_s;
  logic                      mon_roll_s;

  assign bus_s     = {seg7_sel, seg7_in, dpt_in};
  assign tick_s    = enable & (div_cnt_r == DIV_LAST);
  assign same_s    = (bus_s == sample_r);
  // A commit only fires on the STABLE-1 -> STABLE step, so a saturated run stays quiet.
  assign commit_s  = tick_s & same_s & (stable_cnt_r == STABLE_PRE);
  assign dec_s     = decode_seg(sample_r[7:1]);
  assign legal_s   = dec_s[5];
  assign illegal_s = ~dec_s[5] & ~dec_s[4];
  assign val_s     = dec_s[3:0];

  // One-hot commit target; selects beyond the tracked digits match no position.
  always_comb begin
    commit_bit_s = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (commit_s && (32'(sample_r[10:8]) == k)) begin
        commit_bit_s[k] = 1'b1;
      end else begin
        commit_bit_s[k] = 1'b0;
      end
    end
  end

  assign mask_next_s  = mask_r | commit_bit_s;
  assign frame_full_s = &mask_next_s;
  assign mon_roll_s   = commit_bit_s[MON_DIGIT] & legal_s & (val_s == 4'd0) &
                        digit_valid_r[MON_DIGIT] &
                        (digit_bcd_r[4*MON_DIGIT +: 4] == 4'd9);

  // Sample-rate divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= '0;
    end else if (tick_s) begin
      div_cnt_r <= '0;
    end else if (enable) begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Glitch filter: sample register and saturating run-length counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_r     <= 11'd0;
      stable_cnt_r <= '0;
    end else if (tick_s) begin
      if (!same_s) begin
        sample_r     <= bus_s;
        stable_cnt_r <= CNT_W'(1);
      end else if (stable_cnt_r != STABLE_MAX) begin
        stable_cnt_r <= stable_cnt_r + CNT_W'(1);
      end
    end
  end

  // Per-digit BCD, validity and decimal point; blank and illegal keep the old BCD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_bcd_r   <= '0;
      digit_valid_r <= '0;
      dp_flags_r    <= '0;
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (commit_bit_s[k]) begin
          if (legal_s) begin
            digit_bcd_r[4*k +: 4] <= val_s;
            digit_valid_r[k]      <= 1'b1;
          end else begin
            digit_valid_r[k]      <= 1'b0;
          end
          dp_flags_r[k] <= sample_r[0];
        end
      end
    end
  end

  // Sticky error flag; a coincident illegal commit beats the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern_err_r <= 1'b0;
    end else if (commit_s && illegal_s && (|commit_bit_s)) begin
      pattern_err_r <= 1'b1;
    end else if (err_clr) begin
      pattern_err_r <= 1'b0;
    end
  end

  // Frame tracking; a commit landing in the pulse cycle seeds the next frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_r       <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= frame_full_s;
      mask_r       <= frame_full_s ? '0 : mask_next_s;
    end
  end

  // Recovered carry on the monitored digit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rollover_r     <= 1'b0;
      rollover_cnt_r <= 16'd0;
    end else begin
      rollover_r <= mon_roll_s;
      if (mon_roll_s) begin
        rollover_cnt_r <= rollover_cnt_r + 16'd1;
      end
    end
  end

  assign digit_bcd    = digit_bcd_r;
  assign digit_valid  = digit_valid_r;
  assign dp_flags     = dp_flags_r;
  assign frame_done   = frame_done_r;
  assign pattern_err  = pattern_err_r;
  assign rollover     = rollover_r;
  assign rollover_cnt = rollover_cnt_r;

endmodule
